// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned display lines in, decoded digits out
//
// Purpose: bundles the multiplexed seven-segment lines and the decoded results.
// Ports (signals):
//   lit        [3:0]  digit enables, active low
//   dig        [6:0]  segments, active low, {g,f,e,d,c,b,a}
//   value      [15:0] decoded hex digits, nibble k for lit[k]=0
//   valid      [3:0]  per-digit recently refreshed glyph
//   blank      [3:0]  per-digit last capture was all segments off
//   frame_done        one-cycle pulse when all four digits were captured
//   seg_err           one-cycle pulse on an undecodable capture
// Modports: master drives the display lines, slave is the decoder.

interface seg_scan_decoder_if;
    logic [3:0]  lit;
    logic [6:0]  dig;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        frame_done;
    logic        seg_err;

    modport master (
        output lit,
        output dig,
        input  value,
        input  valid,
        input  blank,
        input  frame_done,
        input  seg_err
    );

    modport slave (
        input  lit,
        input  dig,
        output value,
        output valid,
        output blank,
        output frame_done,
        output seg_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds four hex digits from a scanned 7-seg display
//
// Purpose: samples the multiplexed anode/segment lines, waits for a stable
// pattern, decodes the glyph and tracks per-digit freshness.
// Ports:
//   CLK_50M  system clock
//   RST      asynchronous reset, active high
//   bus      seg_scan_decoder_if.slave (lit/dig in; value/valid/blank/frame_done/seg_err out)

module seg_scan_decoder #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic              CLK_50M,
    input  logic              RST,
    seg_scan_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO         = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t           state;
    logic [3:0]       lit_m, lit_s;
    logic [6:0]       dig_m, dig_s;
    logic [10:0]      p_prev;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] tcnt [4];
    logic [3:0]       seen;

    logic [15:0]      value_r;
    logic [3:0]       valid_r;
    logic [3:0]       blank_r;
    logic             frame_done_r;
    logic             seg_err_r;

    logic [3:0]       nlit;
    logic             one_hot;
    logic             changed;
    logic [1:0]       cap_k;
    logic             glyph_ok;
    logic [3:0]       glyph_code;
    logic             is_blank;
    logic             cap_fire;
    logic             cap_good;
    logic             cap_bad;
    logic [3:0]       timed_out;
    logic [3:0]       seen_upd;
    logic             frame_hit;

    assign bus.value      = value_r;
    assign bus.valid      = valid_r;
    assign bus.blank      = blank_r;
    assign bus.frame_done = frame_done_r;
    assign bus.seg_err    = seg_err_r;

    always_comb begin
        nlit    = ~lit_s;
        // exactly one enable driven low
        one_hot = (nlit != 4'd0) && ((nlit & (nlit - 4'd1)) == 4'd0);
        changed = ({lit_s, dig_s} != p_prev);

        cap_k = 2'd0;
        case (nlit)
            4'b0010: cap_k = 2'd1;
            4'b0100: cap_k = 2'd2;
            4'b1000: cap_k = 2'd3;
            default: cap_k = 2'd0;
        endcase

        glyph_ok   = 1'b1;
        glyph_code = 4'h0;
        case (dig_s)
            7'h40: glyph_code = 4'h0;
            7'h79: glyph_code = 4'h1;
            7'h24: glyph_code = 4'h2;
            7'h30: glyph_code = 4'h3;
            7'h19: glyph_code = 4'h4;
            7'h12: glyph_code = 4'h5;
            7'h02: glyph_code = 4'h6;
            7'h78: glyph_code = 4'h7;
            7'h00: glyph_code = 4'h8;
            7'h10: glyph_code = 4'h9;
            7'h08: glyph_code = 4'hA;
            7'h03: glyph_code = 4'hB;
            7'h46: glyph_code = 4'hC;
            7'h21: glyph_code = 4'hD;
            7'h06: glyph_code = 4'hE;
            7'h0E: glyph_code = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
        is_blank = (dig_s == 7'h7F);

        // capture fires on the last settle cycle of an unchanged, single-digit pattern
        cap_fire = (state == SETTLE) && one_hot && !changed && (settle_cnt == SETTLE_LAST);
        cap_good = cap_fire && (glyph_ok || is_blank);
        cap_bad  = cap_fire && !glyph_ok && !is_blank;

        for (int k = 0; k < 4; k++) begin
            timed_out[k] = (tcnt[k] == TMO);
        end

        // timeout clears first, a same-cycle capture then wins
        seen_upd = seen & ~timed_out;
        if (cap_good) begin
            seen_upd[cap_k] = 1'b1;
        end
        frame_hit = cap_good && (seen_upd == 4'hF);
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            lit_m        <= 4'd0;
            lit_s        <= 4'd0;
            dig_m        <= 7'd0;
            dig_s        <= 7'd0;
            p_prev       <= 11'd0;
            settle_cnt   <= '0;
            seen         <= 4'd0;
            value_r      <= 16'd0;
            valid_r      <= 4'd0;
            blank_r      <= 4'd0;
            frame_done_r <= 1'b0;
            seg_err_r    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                tcnt[k] <= '0;
            end
        end else begin
            lit_m  <= bus.lit;
            lit_s  <= lit_m;
            dig_m  <= bus.dig;
            dig_s  <= dig_m;
            p_prev <= {lit_s, dig_s};

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!one_hot) begin
                        state <= IDLE;
                    end else if (changed) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= HELD;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (changed) begin
                        if (one_hot) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            for (int k = 0; k < 4; k++) begin
                if (cap_good && (cap_k == 2'(k))) begin
                    tcnt[k] <= '0;
                end else if (!timed_out[k]) begin
                    tcnt[k] <= tcnt[k] + 1'b1;
                end
                if (timed_out[k]) begin
                    valid_r[k] <= 1'b0;
                    blank_r[k] <= 1'b0;
                end
            end

            if (cap_good) begin
                valid_r[cap_k] <= 1'b1;
                blank_r[cap_k] <= is_blank;
                if (!is_blank) begin
                    value_r[{cap_k, 2'b00} +: 4] <= glyph_code;
                end
            end

            seen         <= frame_hit ? 4'd0 : seen_upd;
            frame_done_r <= frame_hit;
            seg_err_r    <= cap_bad;
        end
    end

endmodule
